// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through byte FIFO with single-cycle error pulses.
module uart_rx_fifo #(
    parameter int unsigned baud_rate    = 57600,
    parameter int unsigned sys_clk_freq = 16000000,
    parameter int unsigned fifo_depth   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(fifo_depth):0]   count,
    output logic                          busy,
    output logic                          frame_error,
    output logic                          overflow,
    output logic                          parity_error
);
    localparam int unsigned C  = sys_clk_freq / baud_rate;
    localparam int unsigned H  = C / 2;
    localparam int unsigned TW = $clog2(C);
    localparam int unsigned AW = $clog2(fifo_depth);
    localparam logic [TW-1:0] T_FULL = TW'(C - 1);
    localparam logic [TW-1:0] T_HALF = TW'(H - 1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(fifo_depth);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic          sync_a;
    logic          line;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          parity_bad;
    logic          tick_full;
    logic          stop_sample;
    logic          push;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b1;
            line   <= 1'b1;
        end else begin
            sync_a <= rx;
            line   <= sync_a;
        end
    end

    assign tick_full   = (timer == T_FULL);
    assign stop_sample = (state == S_STOP) && tick_full;
    assign push        = stop_sample && line && !parity_bad;
    assign busy        = (state != S_IDLE);

`ifndef UART_RX_PARITY_EN
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
`endif
        end else begin
            frame_error  <= stop_sample && !line;
            parity_error <= stop_sample && line && parity_bad;
            timer        <= timer + TW'(1);
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (!line) state <= S_START;
                end
                S_START: begin
                    if (timer == T_HALF) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= line ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_full) begin
                        timer   <= '0;
                        shift   <= {line, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_full) begin
                        timer      <= '0;
                        parity_bad <= ^{shift, line};
                        state      <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_full) begin
                        timer <= '0;
                        state <= line ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    timer <= '0;
                    if (line) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [7:0]    mem [fifo_depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign pop     = rd_en && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push && (!full || rd_en);
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !rd_en;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: random and directed frames against a
// queue-based reference model; a monitor checks every pop and error pulse.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int unsigned BAUD  = 1000000;
    localparam int unsigned FCLK  = 16000000;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned C     = FCLK / BAUD;
    localparam int unsigned H     = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NB = 10;
`else
    localparam int unsigned NB = 9;
`endif
    // rx driven low in cycle 0 reaches the synchronizer output in cycle 2
    localparam int unsigned LAT = 2 + H + NB * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, busy, frame_error, overflow, parity_error;
    logic [3:0] count;

    uart_rx_fifo #(.baud_rate(BAUD), .sys_clk_freq(FCLK), .fifo_depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .busy(busy),
        .frame_error(frame_error), .overflow(overflow), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int occ = 0;
    int fe_exp = 0, of_exp = 0, pe_exp = 0;
    int fe_seen = 0, of_seen = 0, pe_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_error)  fe_seen++;
            if (overflow)     of_seen++;
            if (parity_error) pe_seen++;
            if (rd_en && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0d required no data", rd_data);
                end else begin
                    chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input bit pb, input int c);
        int k = c / int'(C);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return (^d) ^ pb;
    endfunction

    // Reference model: outcome of one frame decided from the framing rules.
    task automatic model_frame(input logic [7:0] d, input bit stop_bad, input bit par_bad,
                               input bit rd_on_stop);
        if (rd_on_stop && occ > 0) occ--;
        if (stop_bad) fe_exp++;
        else if (par_bad) pe_exp++;
        else if (occ < int'(DEPTH)) begin
            exp_q.push_back(d);
            occ++;
        end else of_exp++;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bad, input bit par_bad,
                              input int stop_len, input bit rd_on_stop, input bit lat_chk);
        model_frame(d, stop_bad, par_bad, rd_on_stop);
        for (int c = 0; c < int'(NB * C) + stop_len; c++) begin
            rx    = (c < int'(NB * C)) ? frame_bit(d, par_bad, c) : !stop_bad;
            rd_en = rd_on_stop && (c == int'(LAT) - 1);
            if (lat_chk && c == int'(LAT) - 1) chk("latency_empty_before", int'(empty), 1);
            if (lat_chk && c == int'(LAT))     chk("latency_empty_after", int'(empty), 0);
            tick(1);
        end
        rd_en = 1'b0;
    endtask

    task automatic pop_one();
        if (occ > 0) occ--;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic checkpoint(input string tag);
        tick(2);
        chk({tag, ":count"}, int'(count), occ);
        chk({tag, ":empty"}, int'(empty), int'(occ == 0));
        chk({tag, ":full"}, int'(full), int'(occ == int'(DEPTH)));
        chk({tag, ":busy"}, int'(busy), 0);
        chk({tag, ":frame_error"}, fe_seen, fe_exp);
        chk({tag, ":overflow"}, of_seen, of_exp);
        chk({tag, ":parity_error"}, pe_seen, pe_exp);
    endtask

    initial begin
        bit saw_hi, fell;
        logic [7:0] d;
        tick(3);
        chk("reset:rd_data", int'(rd_data), 0);
        chk("reset:empty", int'(empty), 1);
        chk("reset:full", int'(full), 0);
        chk("reset:count", int'(count), 0);
        chk("reset:busy", int'(busy), 0);
        chk("reset:pulses", int'({frame_error, overflow, parity_error}), 0);
        rst = 1'b0;
        tick(3);

        send_frame(8'h55, 0, 0, 16, 0, 1);
        chk("single:rd_data", int'(rd_data), 8'h55);
        checkpoint("single");
        pop_one();
        checkpoint("single_pop");

        send_frame(8'h57, 0, 0, 9, 0, 0);
        send_frame(8'h65, 0, 0, 9, 0, 0);
        send_frame(8'h6C, 0, 0, 16, 0, 0);
        checkpoint("b2b");
        repeat (3) pop_one();
        pop_one();
        checkpoint("b2b_drain");

        saw_hi = 0;
        fell = 0;
        for (int c = 0; c < 40; c++) begin
            rx = (c < 4) ? 1'b0 : 1'b1;
            if (busy) saw_hi = 1;
            else if (saw_hi) fell = 1;
            tick(1);
        end
        chk("glitch:busy_rose", int'(saw_hi), 1);
        chk("glitch:busy_fell", int'(fell), 1);
        checkpoint("glitch");

        send_frame(8'hA5, 1, 0, 40, 0, 0);
        rx = 1'b1;
        tick(4);
        send_frame(8'h0A, 0, 0, 16, 0, 0);
        checkpoint("frame_err");
        pop_one();

        for (int i = 0; i < int'(DEPTH); i++) send_frame(8'(8'h10 + i), 0, 0, 16, 0, 0);
        checkpoint("fill");
        send_frame(8'hFF, 0, 0, 16, 0, 0);
        checkpoint("overflow");
        send_frame(8'hFF, 0, 0, 16, 1, 0);
        checkpoint("overflow_rd");
        repeat (DEPTH) pop_one();
        checkpoint("overflow_drain");
        send_frame(8'h3C, 0, 0, 16, 1, 0);
        checkpoint("push_empty_rd");

        send_frame(8'h21, 0, 0, 16, 0, 0);
        for (int c = 0; c < 60; c++) begin
            rx = frame_bit(8'h33, 0, c);
            tick(1);
        end
        rst = 1'b1;
        rx = 1'b1;
        tick(1);
        exp_q.delete();
        occ = 0;
        chk("midreset:empty", int'(empty), 1);
        chk("midreset:busy", int'(busy), 0);
        chk("midreset:count", int'(count), 0);
        chk("midreset:rd_data", int'(rd_data), 0);
        rst = 1'b0;
        tick(2);
        send_frame(8'h44, 0, 0, 16, 0, 0);
        chk("after_reset:rd_data", int'(rd_data), 8'h44);
        checkpoint("after_reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 0, 1, 16, 0, 0);
        checkpoint("parity_err");
        send_frame(8'h07, 0, 0, 16, 0, 0);
        checkpoint("parity_ok");
`endif

        for (int it = 0; it < 45; it++) begin
            bit sb, pb, ros;
            d = 8'($urandom);
            sb = ($urandom_range(0, 7) == 0);
`ifdef UART_RX_PARITY_EN
            pb = ($urandom_range(0, 7) == 0);
`else
            pb = 0;
`endif
            if (sb) begin
                send_frame(d, 1, pb, 16 + int'($urandom_range(0, 30)), 0, 0);
                rx = 1'b1;
                tick(int'($urandom_range(2, 6)));
            end else if ($urandom_range(0, 2) == 0) begin
                send_frame(d, 0, pb, 9, 0, 0);
            end else begin
                ros = ($urandom_range(0, 5) == 0);
                send_frame(d, 0, pb, 16, ros, 0);
                tick(int'($urandom_range(4, 12)));
                repeat ($urandom_range(0, 3)) pop_one();
                if ($urandom_range(0, 2) == 0) checkpoint("random");
            end
        end
        tick(4);
        repeat (DEPTH + 1) pop_one();
        checkpoint("final");
        chk("final:scoreboard_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone UART receive path: deserializes an 8-bit, LSB-first asynchronous serial stream on `rx` and buffers completed bytes in a small first-word-fall-through FIFO that downstream logic drains at its own pace. It is the receiving end of the line our UART transmit designs drive: the greeting and echo traffic at 57600 baud on the TinyFPGA BX 16 MHz clock. Framing, overflow and optional parity errors are reported as single-cycle pulses.

## Interface
- `baud_rate`, 57600, serial bit rate.
- `sys_clk_freq`, 16000000, `clk` frequency in Hz; C = sys_clk_freq / baud_rate (integer, truncating), H = C/2 (truncating); C ≥ 4 required.
- `fifo_depth`, 8, FIFO entries; power of two, ≥ 2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input; idle high.
- `rd_en` in 1: pop head entry; ignored while `empty`.
- `rd_data` out 8: FIFO head, valid while `!empty`; reset 0x00.
- `empty` out 1: FIFO empty; reset 1.
- `full` out 1: FIFO full; reset 0.
- `count` out clog2(fifo_depth)+1: occupancy; reset 0.
- `busy` out 1: frame in progress (state ≠ IDLE); reset 0.
- `frame_error` out 1: 1-cycle pulse, stop bit sampled low; reset 0.
- `overflow` out 1: 1-cycle pulse, good byte dropped because FIFO full; reset 0.
- `parity_error` out 1: 1-cycle pulse, parity mismatch; constant 0 without the macro; reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1); "line" below means the synchronizer output.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK. One bit-timer counter and one 3-bit bit index.
- IDLE: line 0 → START, timer cleared.
- START: at timer = H−1, sample line; 0 → DATA, timer cleared; 1 → IDLE (glitch, no error pulse).
- DATA: every C cycles sample one bit into the shift register, LSB first; after bit 7 → PARITY (macro) or STOP.
- PARITY: sample after C cycles; even parity over data plus parity bit checked.
- STOP: sample after C cycles. Line 1 and parity OK → push byte, → IDLE. Line 1 and parity bad → `parity_error`, byte dropped, → IDLE. Line 0 → `frame_error`, byte dropped, → BREAK (parity result ignored).
- BREAK: wait until line 1, then → IDLE; no start detection while in BREAK.
- Push while full: `overflow`, byte dropped, FIFO unchanged — unless `rd_en` asserted in the same cycle, in which case pop and push both occur and `count` stays at fifo_depth.
- Push while empty with `rd_en` high: `rd_en` ignored, push occurs.
- Read/write pointers wrap modulo fifo_depth; `count` is authoritative for `full` and `empty`.
- `rst` at any point, including mid-frame: FSM → IDLE, timer, bit index and pointers cleared, FIFO contents discarded, all outputs to their reset values on the next edge.

## Timing
- Let T0 be the first cycle the line reads 0 in IDLE.
- Start bit sampled at T0+H; data bit i at T0+H+(i+1)·C; parity at T0+H+9·C; stop at T0+H+9·C (8N1) or T0+H+10·C (8E1).
- Push, error pulses, `empty`/`count`/`rd_data` updates are registered: visible one cycle after the stop sample.
- `busy` rises at T0+1 and falls on the cycle the FSM enters IDLE.
- Pop: `rd_data` shows the next entry, `count` decrements, the cycle after `rd_en`.
- Back-to-back frames: a start edge in the cycle immediately following return to IDLE is accepted.

## Configuration
- `UART_RX_PARITY_EN` defined: 8E1 framing, PARITY state present, `parity_error` active.
- Not defined: 8N1 framing, no PARITY state, `parity_error` tied 0.

## Test plan
Bench parameters: baud_rate 1000000, sys_clk_freq 16000000 (C=16, H=8), fifo_depth 8.
- 8N1 frame 0x55 at 16 clocks/bit → `empty` low at T0+153, `rd_data`=0x55, `count`=1, no error pulses.
- Frames 0x57, 0x65, 0x6C back-to-back, no pops → `count`=3; three pops return 0x57, 0x65, 0x6C in order; `empty` after third.
- `rx` low for 4 cycles then high → no push, no error pulse, `busy` high then low, FSM in IDLE.
- Frame 0xA5 with stop bit 0, line held low 40 cycles, then 0x0A → one `frame_error` pulse, 0xA5 not stored, 0x0A stored.
- Fill 8 bytes, send 0xFF → `overflow` pulse, `count`=8, head unchanged; repeat with `rd_en` on the push cycle → 0xFF stored, `count`=8.
- Assert `rst` during DATA of 0x33 → `empty`=1, `busy`=0 next cycle; following 0x44 received cleanly. With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `parity_error` pulse, byte dropped.
